// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned fetch requests under a shared
// credit limit, tracks in-flight PCs, and buffers returned words for decode.
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0100_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_insn,
  input  logic        f_ready
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic idx_t next_idx(input idx_t i);
    return (i == idx_t'(DEPTH - 1)) ? '0 : i + idx_t'(1);
  endfunction

  logic [31:0] pc_q, pc_d;

  logic [31:0] ifq_pc_q [DEPTH];
  logic [31:0] ifq_pc_d [DEPTH];
  idx_t        ifq_wr_q, ifq_wr_d;
  idx_t        ifq_rd_q, ifq_rd_d;
  cnt_t        inflight_q, inflight_d;
  cnt_t        drop_q, drop_d;

  logic [31:0] ofq_pc_q   [DEPTH];
  logic [31:0] ofq_pc_d   [DEPTH];
  logic [31:0] ofq_insn_q [DEPTH];
  logic [31:0] ofq_insn_d [DEPTH];
  idx_t        ofq_wr_q, ofq_wr_d;
  idx_t        ofq_rd_q, ofq_rd_d;
  cnt_t        ofq_cnt_q, ofq_cnt_d;

  logic [CNT_W:0] credit_used;
  logic           req_fire;
  logic           rsp_fire;
  logic           rsp_keep;
  logic           f_push;
  logic           f_pop;

  // Buffered words hold credit too, so a stalled decode throttles fetch.
  assign credit_used    = {1'b0, inflight_q} + {1'b0, ofq_cnt_q};
  assign imem_req_valid = (credit_used < (CNT_W+1)'(DEPTH)) && !redirect_valid && !reset;
  assign imem_req_addr  = {pc_q[31:2], 2'b00};
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire = imem_rsp_valid && (inflight_q != '0);
  assign rsp_keep = rsp_fire && (drop_q == '0) && !redirect_valid;
  assign f_pop    = (ofq_cnt_q != '0) && f_ready && !redirect_valid;
  assign f_push   = rsp_keep && ((ofq_cnt_q != cnt_t'(DEPTH)) || f_pop);

  assign f_valid = (ofq_cnt_q != '0);
  assign f_pc    = ofq_pc_q[ofq_rd_q];
  assign f_insn  = ofq_insn_q[ofq_rd_q];

  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    pc_d       = pc_q;
    ifq_pc_d   = ifq_pc_q;
    ifq_wr_d   = ifq_wr_q;
    ifq_rd_d   = ifq_rd_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    ofq_pc_d   = ofq_pc_q;
    ofq_insn_d = ofq_insn_q;
    ofq_wr_d   = ofq_wr_q;
    ofq_rd_d   = ofq_rd_q;
    ofq_cnt_d  = ofq_cnt_q;

    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (req_fire) begin
      pc_d = pc_q + 32'd4;
    end

    if (req_fire) begin
      ifq_pc_d[ifq_wr_q] = pc_q;
      ifq_wr_d           = next_idx(ifq_wr_q);
    end
    if (rsp_fire) begin
      ifq_rd_d = next_idx(ifq_rd_q);
    end
    inflight_d = inflight_q + cnt_t'(req_fire) - cnt_t'(rsp_fire);

    // Everything still outstanding at a redirect belongs to the old path.
    if (redirect_valid) begin
      drop_d = inflight_q - cnt_t'(rsp_fire);
    end else if (rsp_fire && (drop_q != '0)) begin
      drop_d = drop_q - cnt_t'(1);
    end

    if (redirect_valid) begin
      ofq_wr_d  = '0;
      ofq_rd_d  = '0;
      ofq_cnt_d = '0;
    end else begin
      if (f_push) begin
        ofq_pc_d[ofq_wr_q]   = ifq_pc_q[ifq_rd_q];
        ofq_insn_d[ofq_wr_q] = imem_rsp_data;
        ofq_wr_d             = next_idx(ofq_wr_q);
      end
      if (f_pop) begin
        ofq_rd_d = next_idx(ofq_rd_q);
      end
      ofq_cnt_d = ofq_cnt_q + cnt_t'(f_push) - cnt_t'(f_pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q       <= PC_RESET;
      ifq_wr_q   <= '0;
      ifq_rd_q   <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      ofq_wr_q   <= '0;
      ofq_rd_q   <= '0;
      ofq_cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ifq_pc_q[i]   <= '0;
        ofq_pc_q[i]   <= '0;
        ofq_insn_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      ifq_pc_q   <= ifq_pc_d;
      ifq_wr_q   <= ifq_wr_d;
      ifq_rd_q   <= ifq_rd_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      ofq_pc_q   <= ofq_pc_d;
      ofq_insn_q <= ofq_insn_d;
      ofq_wr_q   <= ofq_wr_d;
      ofq_rd_q   <= ofq_rd_d;
      ofq_cnt_q  <= ofq_cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences for async reset,
// then random traffic against an epoch-tagged memory/decoder reference model.
module tb_fetch_unit;

  localparam logic [31:0] PC_RESET = 32'h0100_0000;
  localparam int          DEPTH    = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_insn;
  logic        f_ready;

  always #5 clock = ~clock;

  fetch_unit #(.PC_RESET(PC_RESET), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .f_valid        (f_valid),
    .f_pc           (f_pc),
    .f_insn         (f_insn),
    .f_ready        (f_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: memory holds accepted requests tagged with the path epoch;
  // a redirect starts a new epoch, and only current-epoch words reach decode.
  logic [31:0] m_pc;
  logic [31:0] pend_addr[$];
  int          pend_ep[$];
  int          epoch;
  logic [31:0] exp_q[$];
  logic [31:0] exp_insn_q[$];
  bit          const_words = 1'b1;

  logic        s_rv, s_fv;
  logic [31:0] s_addr, s_fpc;

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        frdy;
    logic        qrdy;
    logic        rsp;
    logic        bogus;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_fv;
    logic [31:0] e_fpc;
  } vec_t;

  vec_t vt[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (const_words) return 32'h0000_0013;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input int rst, input int redir, input logic [31:0] rpc, input int frdy,
                     input int qrdy, input int rsp, input int bogus, input int e_rv,
                     input logic [31:0] e_addr, input int e_fv, input logic [31:0] e_fpc);
    vec_t v;
    v.rst = (rst != 0);  v.redir = (redir != 0); v.rpc = rpc;
    v.frdy = (frdy != 0); v.qrdy = (qrdy != 0);  v.rsp = (rsp != 0);
    v.bogus = (bogus != 0); v.e_rv = (e_rv != 0); v.e_addr = e_addr;
    v.e_fv = (e_fv != 0);  v.e_fpc = e_fpc;
    vt.push_back(v);
  endtask

  task automatic idle_inputs();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    f_ready        = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
  endtask

  task automatic model_reset();
    m_pc  = PC_RESET;
    epoch = 0;
    pend_addr.delete();
    pend_ep.delete();
    exp_q.delete();
    exp_insn_q.delete();
  endtask

  // Called at a negedge; leaves reset released at the following negedge.
  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    #1;
    check1("rst_req_valid", imem_req_valid, 1'b0);
    check1("rst_f_valid", f_valid, 1'b0);
    check32("rst_f_pc", f_pc, 32'h0);
    check32("rst_f_insn", f_insn, 32'h0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // One clock cycle, entered and left at a negedge.
  task automatic cycle(input logic redir, input logic [31:0] rpc, input logic frdy,
                       input logic qrdy, input logic rsp_en, input logic bogus);
    logic        exp_rv, rsp_fire, acc;
    logic [31:0] a;
    int          e;
    redirect_valid = redir;
    redirect_pc    = rpc;
    f_ready        = frdy;
    imem_req_ready = qrdy;
    rsp_fire       = rsp_en && (pend_addr.size() > 0);
    imem_rsp_valid = rsp_fire || (bogus && (pend_addr.size() == 0));
    imem_rsp_data  = rsp_fire ? word_of(pend_addr[0]) : $urandom;
    #1;
    exp_rv = ((pend_addr.size() + exp_q.size()) < DEPTH) && !redir;
    check1("req_valid", imem_req_valid, exp_rv);
    check32("req_addr", imem_req_addr, m_pc);
    check1("f_valid", f_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check32("f_pc", f_pc, exp_q[0]);
      check32("f_insn", f_insn, exp_insn_q[0]);
    end
    s_rv = imem_req_valid; s_addr = imem_req_addr; s_fv = f_valid; s_fpc = f_pc;

    acc = exp_rv && qrdy;
    if (redir) begin
      if (rsp_fire) begin
        a = pend_addr.pop_front();
        e = pend_ep.pop_front();
      end
      exp_q.delete();
      exp_insn_q.delete();
      epoch++;
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (frdy && exp_q.size() > 0) begin
        a = exp_q.pop_front();
        a = exp_insn_q.pop_front();
      end
      if (rsp_fire) begin
        a = pend_addr.pop_front();
        e = pend_ep.pop_front();
        if (e == epoch) begin
          exp_q.push_back(a);
          exp_insn_q.push_back(word_of(a));
        end
      end
      if (acc) begin
        pend_addr.push_back(m_pc);
        pend_ep.push_back(epoch);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    idle_inputs();
    model_reset();

    // rst redir rpc frdy qrdy rsp bogus | rv addr fv fpc
    // Zero-wait memory, decode always ready.
    add(1,0,32'h0, 1,1,1,0, 1,32'h0100_0000, 0,32'h0);
    add(0,0,32'h0, 1,1,1,0, 1,32'h0100_0004, 0,32'h0);
    add(0,0,32'h0, 1,1,1,0, 0,32'h0100_0008, 1,32'h0100_0000);
    add(0,0,32'h0, 1,1,1,0, 1,32'h0100_0008, 1,32'h0100_0004);
    add(0,0,32'h0, 1,1,1,0, 1,32'h0100_000C, 0,32'h0);
    add(0,0,32'h0, 1,1,1,0, 0,32'h0100_0010, 1,32'h0100_0008);
    // Decode stalled: only two requests, head held, fetch resumes after release.
    add(1,0,32'h0, 0,1,1,0, 1,32'h0100_0000, 0,32'h0);
    add(0,0,32'h0, 0,1,1,0, 1,32'h0100_0004, 0,32'h0);
    for (int i = 0; i < 8; i++) add(0,0,32'h0, 0,1,1,0, 0,32'h0100_0008, 1,32'h0100_0000);
    add(0,0,32'h0, 1,1,1,0, 0,32'h0100_0008, 1,32'h0100_0000);
    add(0,0,32'h0, 1,1,1,0, 1,32'h0100_0008, 1,32'h0100_0004);
    add(0,0,32'h0, 1,1,1,0, 1,32'h0100_000C, 0,32'h0);
    // Redirect with two requests outstanding; both late words are dropped.
    add(1,0,32'h0,          1,1,0,0, 1,32'h0100_0000, 0,32'h0);
    add(0,0,32'h0,          1,1,0,0, 1,32'h0100_0004, 0,32'h0);
    add(0,1,32'h0100_0100,  1,1,0,0, 0,32'h0100_0008, 0,32'h0);
    add(0,0,32'h0,          1,1,1,0, 0,32'h0100_0100, 0,32'h0);
    add(0,0,32'h0,          1,1,1,0, 1,32'h0100_0100, 0,32'h0);
    add(0,0,32'h0,          1,1,1,0, 1,32'h0100_0104, 0,32'h0);
    add(0,0,32'h0,          1,1,1,0, 0,32'h0100_0108, 1,32'h0100_0100);
    // Stray response with nothing outstanding, then an unaligned redirect target.
    add(1,0,32'h0,          1,0,1,1, 1,32'h0100_0000, 0,32'h0);
    add(0,1,32'h0100_0102,  1,0,1,0, 0,32'h0100_0000, 0,32'h0);
    add(0,0,32'h0,          1,1,1,0, 1,32'h0100_0100, 0,32'h0);
    add(0,0,32'h0,          1,1,1,0, 1,32'h0100_0104, 0,32'h0);
    // Redirect to the top word; fetch wraps to zero.
    add(1,1,32'hFFFF_FFFC,  1,1,1,0, 0,32'h0100_0000, 0,32'h0);
    add(0,0,32'h0,          1,1,1,0, 1,32'hFFFF_FFFC, 0,32'h0);
    add(0,0,32'h0,          1,1,1,0, 1,32'h0000_0000, 0,32'h0);
    add(0,0,32'h0,          1,1,1,0, 0,32'h0000_0004, 1,32'hFFFF_FFFC);
    add(0,0,32'h0,          1,1,1,0, 1,32'h0000_0004, 1,32'h0000_0000);

    @(negedge clock);
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].rst) do_reset();
      cycle(vt[i].redir, vt[i].rpc, vt[i].frdy, vt[i].qrdy, vt[i].rsp, vt[i].bogus);
      check1($sformatf("tbl%0d_rv", i), s_rv, vt[i].e_rv);
      check32($sformatf("tbl%0d_addr", i), s_addr, vt[i].e_addr);
      check1($sformatf("tbl%0d_fv", i), s_fv, vt[i].e_fv);
      if (vt[i].e_fv) check32($sformatf("tbl%0d_fpc", i), s_fpc, vt[i].e_fpc);
    end

    // Asynchronous reset in the middle of a burst, away from any clock edge.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    f_ready = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
    #1;
    check1("burst_req_valid", imem_req_valid, 1'b1);
    check1("burst_f_valid", f_valid, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check1("async_req_valid", imem_req_valid, 1'b0);
    check1("async_f_valid", f_valid, 1'b0);
    check32("async_f_pc", f_pc, 32'h0);
    @(posedge clock);
    #1;
    check1("held_f_valid", f_valid, 1'b0);
    @(negedge clock);
    idle_inputs();
    reset = 1'b0;
    model_reset();
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    check1("post_rst_rv", s_rv, 1'b1);
    check32("post_rst_addr", s_addr, 32'h0100_0000);

    // Random traffic against the reference model.
    const_words = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        r_redir;
      logic [31:0] r_pc;
      r_redir = ($urandom_range(0, 19) == 0);
      r_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                            : $urandom;
      cycle(r_redir, r_pc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 1) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
